// File: rtl/asi_core_seq.sv
// asi_core_seq: one-instruction-at-a-time execution core with NREG x DW register file,
// branch/jump pc logic and an iterative shift-add multiplier.
module asi_core_seq #(
  parameter int DW   = 32,
  parameter int NREG = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  input  logic          write_enable,
  output logic          retire,
  output logic          illegal,
  output logic [31:0]   pc,
  output logic [31:0]   ra,
  input  logic [7:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [1:0]    dbg_state
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   instr_q, instr_d, pc_q, pc_d, ra_q, ra_d;
  logic          ready_q, ready_d, retire_q, retire_d, illegal_q, illegal_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [DW-1:0] regs_q [NREG];

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [7:0]    op, shamt;
  logic [AW-1:0] rd_idx, rs2_idx, rs1_idx;
  logic [DW-1:0] rd_val, rs2_val, rs1_val, imm_zx, imm_sx, alu_res, mul_a, mul_b, acc_step;
  logic signed [15:0] imm_s;
  logic          alu_wb, alu_ill, alu_mul;
  logic [31:0]   pc_inc, pc_exec, ra_exec, br_off;
  logic          unused_bits;

  assign op      = instr_q[31:24];
  assign shamt   = instr_q[7:0];
  assign rd_idx  = instr_q[16 +: AW];
  assign rs2_idx = instr_q[8 +: AW];
  assign rs1_idx = instr_q[0 +: AW];
  assign rd_val  = regs_q[rd_idx];
  assign rs2_val = regs_q[rs2_idx];
  assign rs1_val = regs_q[rs1_idx];
  assign imm_s   = instr_q[15:0];
  assign imm_sx  = DW'(imm_s);
  assign imm_zx  = DW'(instr_q[15:0]);
  assign br_off  = 32'(signed'(instr_q[7:0]));
  assign pc_inc  = pc_q + 32'd1;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign unused_bits = ^{dbg_addr, instr_q};

  // Decode/execute of the latched instruction; operands are read from the register file in EXEC.
  always_comb begin
    alu_res = '0;
    alu_wb  = 1'b1;
    alu_ill = 1'b0;
    alu_mul = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    pc_exec = pc_inc;
    ra_exec = ra_q;
    case (op)
      8'h05: alu_res = rs2_val & rs1_val;
      8'h06: alu_res = rs2_val | rs1_val;
      8'h07: alu_res = rs2_val ^ rs1_val;
      8'h08: alu_res = rs2_val + rs1_val;
      8'h09: alu_res = rs2_val - rs1_val;
      8'h0A: begin alu_mul = 1'b1; mul_a = rs2_val; mul_b = rs1_val; end
      8'h45: alu_res = rd_val & imm_zx;
      8'h46: alu_res = rd_val | imm_zx;
      8'h47: alu_res = rd_val ^ imm_zx;
      8'h4A: alu_res = rd_val + imm_sx;
      8'h4B: alu_res = rd_val - imm_sx;
      8'h4C: begin alu_mul = 1'b1; mul_a = rd_val; mul_b = imm_sx; end
      8'h48: alu_res = (int'(shamt) >= DW) ? '0 : (rs2_val << shamt);
      8'h49: alu_res = (int'(shamt) >= DW) ? '0 : (rs2_val >> shamt);
      8'h41: begin alu_wb = 1'b0; if (rd_val == rs2_val) pc_exec = pc_q + br_off; end
      8'h42: begin alu_wb = 1'b0; if (rd_val != rs2_val) pc_exec = pc_q + br_off; end
      8'h43: begin alu_wb = 1'b0; if (rd_val == imm_sx) pc_exec = pc_q + 32'd2; end
      8'h44: begin alu_wb = 1'b0; if (rd_val != imm_sx) pc_exec = pc_q + 32'd2; end
      8'h01: begin alu_wb = 1'b0; pc_exec = {8'd0, instr_q[23:0]}; end
      8'h02: begin alu_wb = 1'b0; pc_exec = {8'd0, instr_q[23:0]}; ra_exec = pc_inc; end
      default: begin alu_wb = 1'b0; alu_ill = 1'b1; end
    endcase
  end

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is registered and high only in IDLE, so valid held during EXEC/MUL is ignored.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    ra_d      = ra_q;
    ready_d   = ready_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    wr_en     = 1'b0;
    wr_data   = alu_res;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (instr_valid && ready_q) begin
          instr_d = instr;
          ready_d = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_mul) begin
          state_d  = S_MUL;
          mcand_d  = mul_a;
          mplier_d = mul_b;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d   = S_IDLE;
          ready_d   = 1'b1;
          retire_d  = 1'b1;
          illegal_d = alu_ill;
          pc_d      = pc_exec;
          ra_d      = ra_exec;
          wr_en     = alu_wb && write_enable && (rd_idx != '0);
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d  = S_IDLE;
          ready_d  = 1'b1;
          retire_d = 1'b1;
          pc_d     = pc_inc;
          cnt_d    = '0;
          wr_data  = acc_step;
          wr_en    = write_enable && (rd_idx != '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      pc_q      <= '0;
      ra_q      <= '0;
      ready_q   <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      ra_q      <= ra_d;
      ready_q   <= ready_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      if (wr_en) regs_q[rd_idx] <= wr_data;
    end
  end

  assign instr_ready = ready_q;
  assign retire      = retire_q;
  assign illegal     = illegal_q;
  assign pc          = pc_q;
  assign ra          = ra_q;
  assign dbg_state   = state_q;
  assign dbg_data    = (dbg_addr[AW-1:0] == '0) ? '0 : regs_q[dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_asi_core_seq.sv
// Bench for asi_core_seq: ISA reference model pushes expected retire records,
// a negedge monitor pops and compares them when retire pulses.
module tb_asi_core_seq;
  localparam int DW   = 32;
  localparam int NREG = 64;
  localparam int EW   = 32 + 32 + 1 + DW + 8;

  logic          clock, reset, instr_valid, instr_ready, write_enable, retire, illegal;
  logic [31:0]   instr, pc, ra;
  logic [7:0]    dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [1:0]    dbg_state;

  asi_core_seq #(.DW(DW), .NREG(NREG)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .write_enable(write_enable), .retire(retire), .illegal(illegal),
    .pc(pc), .ra(ra), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_regs [NREG];
  logic [31:0]   m_pc, m_ra;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_pc = '0;
    m_ra = '0;
  endtask

  // Reference ISA model: updates architectural state and queues the expected retire record.
  task automatic model_exec(input logic [31:0] ins, input bit we);
    logic [7:0]  op, k;
    logic [5:0]  d, b, a;
    logic [31:0] sx, zx, res, npc;
    bit          wb, ill;
    int          lat;
    op = ins[31:24]; d = ins[21:16]; b = ins[13:8]; a = ins[5:0]; k = ins[7:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'd0, ins[15:0]};
    res = '0; npc = m_pc + 1; wb = 1'b1; ill = 1'b0; lat = 1;
    case (op)
      8'h05: res = m_regs[b] & m_regs[a];
      8'h06: res = m_regs[b] | m_regs[a];
      8'h07: res = m_regs[b] ^ m_regs[a];
      8'h08: res = m_regs[b] + m_regs[a];
      8'h09: res = m_regs[b] - m_regs[a];
      8'h0A: begin res = m_regs[b] * m_regs[a]; lat = 1 + DW; end
      8'h45: res = m_regs[d] & zx;
      8'h46: res = m_regs[d] | zx;
      8'h47: res = m_regs[d] ^ zx;
      8'h4A: res = m_regs[d] + sx;
      8'h4B: res = m_regs[d] - sx;
      8'h4C: begin res = m_regs[d] * sx; lat = 1 + DW; end
      8'h48: res = (k >= 8'd32) ? 32'd0 : (m_regs[b] << k);
      8'h49: res = (k >= 8'd32) ? 32'd0 : (m_regs[b] >> k);
      8'h41: begin wb = 1'b0; if (m_regs[d] == m_regs[b]) npc = m_pc + {{24{k[7]}}, k}; end
      8'h42: begin wb = 1'b0; if (m_regs[d] != m_regs[b]) npc = m_pc + {{24{k[7]}}, k}; end
      8'h43: begin wb = 1'b0; if (m_regs[d] == sx) npc = m_pc + 2; end
      8'h44: begin wb = 1'b0; if (m_regs[d] != sx) npc = m_pc + 2; end
      8'h01: begin wb = 1'b0; npc = {8'd0, ins[23:0]}; end
      8'h02: begin wb = 1'b0; npc = {8'd0, ins[23:0]}; m_ra = m_pc + 1; end
      default: begin wb = 1'b0; ill = 1'b1; end
    endcase
    if (wb && we && d != 6'd0) m_regs[d] = res;
    m_pc = npc;
    exp_q.push_back({m_pc, m_ra, ill, m_regs[d], 8'(lat)});
  endtask

  // driver tasks
  task automatic issue(input logic [31:0] ins, input bit we, input bit hold);
    int n;
    model_exec(ins, we);
    dbg_addr = {2'b00, ins[21:16]};
    write_enable = we;
    n = 0;
    @(negedge clock);
    while (!instr_ready && n < 50) begin @(negedge clock); n++; end
    if (!instr_ready) check("ready_timeout", 64'(instr_ready), 64'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    xfer_cyc = cyc;
    if (hold) instr = 32'h4A050001;
    else instr_valid = 1'b0;
  endtask

  task automatic finish_instr();
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!retire && n < DW + 10);
    if (!retire) begin
      check("retire_timeout", 64'(retire), 64'd1);
      exp_q.delete();
    end
    instr_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic send(input logic [31:0] ins, input bit we);
    issue(ins, we, 1'b0);
    finish_instr();
  endtask

  // scoreboard monitor
  logic chk_pulse = 1'b0;
  always @(negedge clock) begin : monitor
    logic [EW-1:0] r;
    if (chk_pulse) begin
      check("retire_pulse", 64'(retire), 64'd0);
      check("ready_after", 64'(instr_ready), 64'd1);
    end
    chk_pulse <= 1'b0;
    if (!reset && retire) begin
      if (exp_q.size() == 0) check("unexp_retire", 64'(retire), 64'd0);
      else begin
        r = exp_q.pop_front();
        check("pc", 64'(pc), 64'(r[EW-1 -: 32]));
        check("ra", 64'(ra), 64'(r[EW-33 -: 32]));
        check("illegal", 64'(illegal), 64'(r[DW+8]));
        check("reg", 64'(dbg_data), 64'(r[DW+7 -: DW]));
        check("latency", 64'(cyc - xfer_cyc), 64'(r[7:0]));
        chk_pulse <= 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] ops [12] = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h45,
                           8'h46, 8'h47, 8'h4A, 8'h4B, 8'h48, 8'h49};

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; write_enable = 1'b1; dbg_addr = 8'd1;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_ra", 64'(ra), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_ready", 64'(instr_ready), 64'd0);
    check("rst_reg", 64'(dbg_data), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_post_rst", 64'(instr_ready), 64'd1);

    // load + register-register ops
    send(32'h4A010F0F, 1'b1);
    send(32'h4A0200FF, 1'b1);
    send(32'h05030201, 1'b1);
    send(32'h06040201, 1'b1);
    send(32'h07050201, 1'b1);
    send(32'h08060201, 1'b1);
    send(32'h09070102, 1'b1);

    // multiplies, with valid held high through MUL
    send(32'h4A10012C, 1'b1);
    send(32'h4A110064, 1'b1);
    issue(32'h0A121110, 1'b1, 1'b1);
    finish_instr();
    send(32'h4B10012D, 1'b1);
    issue(32'h0A121110, 1'b1, 1'b1);
    finish_instr();
    send(32'h4C11FFFD, 1'b1);

    // branches
    send(32'h4A1D0005, 1'b1);
    send(32'h4A1E0005, 1'b1);
    send(32'h01000014, 1'b1);
    send(32'h411D1E0A, 1'b1);
    send(32'h4A1E0001, 1'b1);
    send(32'h01000014, 1'b1);
    send(32'h411D1E0A, 1'b1);
    send(32'h421D1EFC, 1'b1);
    send(32'h4426AAAA, 1'b1);
    send(32'h4326AAAA, 1'b1);
    send(32'h01000007, 1'b1);
    send(32'h02F0F0F0, 1'b1);

    // shifts, zero-extended immediates, illegal, write suppression, R0
    send(32'h4A190123, 1'b1);
    send(32'h481A1928, 1'b1);
    send(32'h481A1904, 1'b1);
    send(32'h491B1A04, 1'b1);
    send(32'h481A191F, 1'b1);
    send(32'h46018000, 1'b1);
    send(32'h4701FFFF, 1'b1);
    send(32'h83010203, 1'b1);
    send(32'h00010000, 1'b1);
    send(32'h4A011111, 1'b0);
    send(32'h4A001234, 1'b1);

    // random ALU traffic
    for (int i = 0; i < 20; i++) begin
      logic [7:0]  op;
      logic [31:0] ins;
      op = ops[$urandom_range(0, 11)];
      if (op[6] && op != 8'h48 && op != 8'h49)
        ins = {op, 8'($urandom_range(1, 7)), 16'($urandom_range(0, 65535))};
      else if (op == 8'h48 || op == 8'h49)
        ins = {op, 8'($urandom_range(1, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 40))};
      else
        ins = {op, 8'($urandom_range(1, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
      send(ins, $urandom_range(0, 3) != 0);
    end

    // reset in the middle of a multiply
    issue(32'h0A121110, 1'b1, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check("mrst_pc", 64'(pc), 64'd0);
    check("mrst_ra", 64'(ra), 64'd0);
    check("mrst_retire", 64'(retire), 64'd0);
    check("mrst_illegal", 64'(illegal), 64'd0);
    check("mrst_ready", 64'(instr_ready), 64'd0);
    check("mrst_reg", 64'(dbg_data), 64'd0);
    check("mrst_state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mrst_ready_post", 64'(instr_ready), 64'd1);
    repeat (DW + 4) @(negedge clock);
    send(32'h4A010005, 1'b1);
    send(32'h0A020101, 1'b1);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/asi_core_seq.md
# asi_core_seq

Parametrised successor of the single-cycle `asi` execution core. It accepts one 32-bit instruction at a time over a valid/ready handshake and executes it against an `NREG` x `DW` register file. It updates `pc`/`ra` for branches and jumps, and runs multiplies as an iterative multi-cycle operation. It sits between the instruction source (program ROM or bench driver) and the debug/observation logic.

## Interface
- `DW`, 32: datapath and register width; must be ≥16.
- `NREG`, 64: number of registers; must be a power of two, ≤256. Register index = low log2(NREG) bits of each 8-bit field.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `instr_valid`  in  1: `instr` holds a valid instruction.
- `instr_ready`  out  1: core can accept; high only in IDLE.
- `instr`  in  32: [31:24] opcode, [23:16] Rd/RsA, [15:8] Rs2/RsB, [7:0] Rs1/K/offset, [15:0] imm16, [23:0] target24.
- `write_enable`  in  1: sampled at writeback; 0 suppresses the register write only.
- `retire`  out  1: 1-cycle pulse when an instruction completes.
- `illegal`  out  1: 1-cycle pulse with `retire` for an unknown opcode.
- `pc`  out  32: program counter (instruction index).
- `ra`  out  32: link register.
- `dbg_addr`  in  8: debug read index.
- `dbg_data`  out  DW: combinational read of reg[`dbg_addr`]; R0 reads 0.

## Operation
- Handshake: transfer happens on an edge with `instr_valid` && `instr_ready`. `instr` is latched and the FSM moves IDLE→EXEC. The source holds `instr` until the transfer.
- FSM states:
  - IDLE → EXEC on transfer.
  - EXEC → IDLE (writeback) for all ops except MPLR/MPLI.
  - EXEC → MUL for MPLR/MPLI. MUL counts `DW` cycles, one shift-add bit per cycle, then → IDLE (writeback).
- Register-register ops: Rd=[23:16], Rs2=[15:8], Rs1=[7:0]; result = Rs2 op Rs1.
  - 0x05 ANDR, 0x06 ORR, 0x07 XORR, 0x08 ADDR, 0x09 SUBR (Rs2−Rs1), 0x0A MPLR.
- Immediate ops: Rd op= imm16, in place.
  - 0x45 ANDI, 0x46 ORI, 0x47 XORI zero-extend imm16.
  - 0x4A ADDI, 0x4B SUBI, 0x4C MPLI sign-extend imm16.
- Shifts: 0x48 SLLI and 0x49 SRLI compute Rd = Rs2 <</>> K, with K=[7:0], logical. K ≥ DW gives 0.
- Arithmetic width: all results are modulo 2^DW. MPL keeps the low DW bits of the product.
- R0 is hard-wired to 0; writes to R0 are discarded.
- Branch and jump ops (no register write):
  - 0x41 BEQR / 0x42 BNER compare reg[23:16] with reg[15:8]. Taken: pc ← pc + sext(offset[7:0]); otherwise pc+1.
  - 0x43 BEQI / 0x44 BNEI compare reg[23:16] with sext(imm16). Taken: pc ← pc+2 (skip next); otherwise pc+1.
  - 0x01 J: pc ← zext(target24).
  - 0x02 JAL: ra ← pc+1, then pc ← zext(target24).
- All other opcodes, including 0x81–0x83 (memory ops, not in this block), are illegal: `illegal` pulses, there is no write, and pc ← pc+1.
- Non-branch instructions: pc ← pc+1 at writeback. pc wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (async, while high): FSM = IDLE; `pc`=0, `ra`=0; all registers 0; `retire`=0, `illegal`=0; MUL counter 0. `instr_ready`=1 from the first edge after reset deasserts.
- Single-cycle ops: transfer at edge T, then writeback, pc/ra update and `retire`=1 at edge T+1. `instr_ready` is low during T..T+1 and high after T+1. Maximum throughput is 1 instruction per 2 cycles.
- MPL ops: writeback and `retire` at edge T+1+DW.
- Operand read happens in EXEC, so a result written at T+1 is visible to an instruction transferred at T+1.
- `dbg_data` reflects a write one edge after the write; there is no bypass.
- Reset mid-MUL: aborts immediately; no write, no retire.
- `instr_valid` held high in EXEC/MUL is ignored; no transfer occurs.

## Test plan
- After reset, force R1=0x0F0F, R2=0x00FF via a load sequence (ADDI from R0), then ANDR R3,R2,R1 (0x05030201) → `retire` at T+1, R3=0x000F, pc incremented by 1.
- R16=300, R17=100, MPLR R18,R17,R16 → `instr_ready` low for DW+1 cycles, R18=30000; with R16=0xFFFFFFFF and DW=32, R18 = low 32 bits of the product.
- R29=R30=5, BEQR R29,R30,+10 at pc=20 → pc=30. With R30=6 → pc=21. BNEI R38 (=0), imm 0xAAAA → pc+2.
- JAL 0xF0F0F0 at pc=7 → ra=8, pc=0x00F0F0F0. SLLI R26=R25<<40 with DW=32 → 0.
- Opcode 0x83 → `illegal` and `retire` pulse together, no register change, pc+1. `write_enable`=0 during ADDI → register unchanged, pc+1.
- Assert `reset` at cycle 5 of an MPL → all outputs return to reset values immediately; the next transfer executes normally.
